// File: rtl/iserdes_rx_pkg.sv
// iserdes_rx_pkg: shared state type, default idle byte and window slicing helper
package iserdes_rx_pkg;
  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_e;
  localparam logic [7:0] ALIGN_WORD_DEFAULT = 8'hAC;
  function automatic logic [7:0] cand(input logic [15:0] win, input logic [2:0] k);
    return win[k +: 8];
  endfunction
endpackage

// File: rtl/iserdes_word_aligner_if.sv
// iserdes_word_aligner_if: AXI-Stream style byte channel
interface iserdes_word_aligner_if;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tready;
  modport master (output tdata, tvalid, input tready);
  modport slave (input tdata, tvalid, output tready);
endinterface

// File: rtl/sync_fwft_fifo.sv
// sync_fwft_fifo: small first-word-fall-through FIFO with a registered head
module sync_fwft_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             rd_valid_o,
  output logic             full_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = DEPTH[AW:0];
  localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_d;
  logic [AW:0] cnt_q;
  logic pop, push;
  assign full_o = cnt_q == FULL;
  assign pop = rd_en_i && rd_valid_o;
  assign push = wr_en_i && (!full_o || pop);
  assign rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
  // storage; when full, a same-cycle pop frees the slot the write lands in
  always_ff @(posedge CLK)
    if (push) mem_q[wr_ptr_q] <= wr_data_i;
  // pointers, occupancy and the registered head presented to the consumer
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      rd_data_o  <= '0;
      rd_valid_o <= 1'b0;
    end else begin
      wr_ptr_q   <= push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      rd_data_o  <= mem_q[rd_ptr_d];
      rd_valid_o <= pop ? cnt_q > ONE : cnt_q != '0;
    end
endmodule

// File: rtl/iserdes_word_aligner.sv
// iserdes_word_aligner: hunts the idle byte across bit offsets, locks, and streams payload
module iserdes_word_aligner
  import iserdes_rx_pkg::*;
#(
  parameter logic [7:0] ALIGN_WORD   = ALIGN_WORD_DEFAULT,
  parameter int         LOCK_COUNT   = 4,
  parameter int         UNLOCK_COUNT = 4,
  parameter int         FIFO_DEPTH   = 4,
  parameter bit         DROP_IDLE    = 1'b1
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [7:0]                    rx_data,
  iserdes_word_aligner_if.master        axis,
  output logic                          locked,
  output logic [2:0]                    align_offset,
  output logic                          overflow
);
  localparam logic [3:0] LC = LOCK_COUNT[3:0];
  localparam logic [3:0] UC = UNLOCK_COUNT[3:0];
  state_e state_q, state_d;
  logic [7:0] cur_q, prev_q, word_q, match;
  logic [15:0] win;
  logic [2:0] off_q, off_d, uoff_q, uoff_d, hit_off;
  logic [3:0] cnt_q, cnt_d, ucnt_q, ucnt_d, cnt_inc, ucnt_inc;
  logic word_vld_q, any_hit, wr_en, full, ovf_q;
  assign win = {cur_q, prev_q};
  for (genvar k = 0; k < 8; k++) begin : g_match
    assign match[k] = cand(win, 3'(k)) == ALIGN_WORD;
  end
  assign any_hit = |match;
  assign cnt_inc = cnt_q + 4'd1;
  assign ucnt_inc = (hit_off == uoff_q && ucnt_q != 4'd0) ? ucnt_q + 4'd1 : 4'd1;
  assign wr_en = word_vld_q && !(DROP_IDLE && word_q == ALIGN_WORD);
  assign locked = state_q == LOCKED;
  assign align_offset = off_q;
  assign overflow = ovf_q;
  // lowest matching offset wins when several candidates match
  always_comb begin
    hit_off = 3'd0;
    for (int i = 7; i >= 0; i--) if (match[i]) hit_off = 3'(i);
  end
  // alignment FSM: confirm a candidate offset, then watch for a consistent foreign offset
  always_comb begin
    state_d = state_q;
    off_d   = off_q;
    cnt_d   = cnt_q;
    uoff_d  = uoff_q;
    ucnt_d  = ucnt_q;
    case (state_q)
      SEARCH: if (any_hit) begin
        off_d   = hit_off;
        state_d = LC == 4'd1 ? LOCKED : VERIFY;
        cnt_d   = LC == 4'd1 ? 4'd0 : 4'd1;
      end
      VERIFY: if (match[off_q]) begin
        state_d = cnt_inc == LC ? LOCKED : VERIFY;
        cnt_d   = cnt_inc == LC ? 4'd0 : cnt_inc;
      end else if (any_hit) begin
        off_d = hit_off;
        cnt_d = 4'd1;
      end else begin
        state_d = SEARCH;
        cnt_d   = 4'd0;
      end
      LOCKED: if (!match[off_q] && any_hit) begin
        uoff_d  = hit_off;
        ucnt_d  = ucnt_inc == UC ? 4'd0 : ucnt_inc;
        state_d = ucnt_inc == UC ? SEARCH : LOCKED;
      end else ucnt_d = 4'd0;
      default: state_d = SEARCH;
    endcase
  end
  // input history, FSM state, payload stage and sticky overflow
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      cur_q      <= '0;
      prev_q     <= '0;
      state_q    <= SEARCH;
      off_q      <= '0;
      cnt_q      <= '0;
      uoff_q     <= '0;
      ucnt_q     <= '0;
      word_q     <= '0;
      word_vld_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      cur_q      <= rx_data;
      prev_q     <= cur_q;
      state_q    <= state_d;
      off_q      <= off_d;
      cnt_q      <= cnt_d;
      uoff_q     <= uoff_d;
      ucnt_q     <= ucnt_d;
      word_q     <= cand(win, off_q);
      word_vld_q <= state_q == LOCKED;
      ovf_q      <= ovf_q | (wr_en && full && !(axis.tvalid && axis.tready));
    end
  sync_fwft_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .CLK        (CLK),
    .RST        (RST),
    .wr_en_i    (wr_en),
    .wr_data_i  (word_q),
    .rd_en_i    (axis.tready),
    .rd_data_o  (axis.tdata),
    .rd_valid_o (axis.tvalid),
    .full_o     (full)
  );
endmodule

// File: tb/tb_iserdes_word_aligner.sv
// tb_iserdes_word_aligner: directed scenarios with hand-computed expectations
module tb_iserdes_word_aligner;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic [7:0] last_b = 8'h00;
  logic locked, overflow;
  logic [2:0] align_offset;
  int vecs = 0;
  int errs = 0;

  iserdes_word_aligner_if axis();

  iserdes_word_aligner dut (
    .CLK          (CLK),
    .RST          (RST),
    .rx_data      (rx_data),
    .axis         (axis),
    .locked       (locked),
    .align_offset (align_offset),
    .overflow     (overflow)
  );

  always #5 CLK = ~CLK;

  // byte b placed at bit offset k of the serial stream; advances one clock
  task automatic send(input logic [7:0] b, input int k);
    logic [15:0] t;
    t = {b, last_b} >> (8 - k);
    rx_data = t[7:0];
    last_b = b;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    axis.tready = 1'b0;
    #12;
    vecs++;
    if (axis.tvalid !== 1'b0 || axis.tdata !== 8'h00) begin
      errs++;
      $display("FAIL reset_out: tvalid=%b tdata=%h expected 0/00", axis.tvalid, axis.tdata);
    end
    vecs++;
    if (locked !== 1'b0 || align_offset !== 3'd0 || overflow !== 1'b0) begin
      errs++;
      $display("FAIL reset_status: locked=%b off=%0d ovf=%b expected 0/0/0", locked, align_offset, overflow);
    end
    @(posedge CLK);
    #1;
    RST = 1'b0;
  endtask

  task automatic test_lock();
    axis.tready = 1'b1;
    repeat (5) send(8'hAC, 3);
    vecs++;
    if (locked !== 1'b0) begin
      errs++;
      $display("FAIL lock_early: locked=%b expected 0", locked);
    end
    send(8'hAC, 3);
    vecs++;
    if (locked !== 1'b1 || align_offset !== 3'd3) begin
      errs++;
      $display("FAIL lock_set: locked=%b off=%0d expected 1/3", locked, align_offset);
    end
    repeat (6) send(8'hAC, 3);
    vecs++;
    if (axis.tvalid !== 1'b0) begin
      errs++;
      $display("FAIL idle_drop: tvalid=%b expected 0", axis.tvalid);
    end
  endtask

  task automatic test_payload();
    logic [7:0] p [3];
    p = '{8'h11, 8'h22, 8'h33};
    axis.tready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send(p[i], 3);
      repeat (3) send(8'hAC, 3);
      vecs++;
      if (axis.tvalid !== 1'b0) begin
        errs++;
        $display("FAIL payload_early[%0d]: tvalid=%b expected 0", i, axis.tvalid);
      end
      send(8'hAC, 3);
      vecs++;
      if (axis.tvalid !== 1'b1 || axis.tdata !== p[i]) begin
        errs++;
        $display("FAIL payload_out[%0d]: tvalid=%b tdata=%h expected 1/%h", i, axis.tvalid, axis.tdata, p[i]);
      end
      send(8'hAC, 3);
      vecs++;
      if (axis.tvalid !== 1'b0) begin
        errs++;
        $display("FAIL payload_idle[%0d]: tvalid=%b expected 0", i, axis.tvalid);
      end
    end
  endtask

  task automatic test_overflow();
    axis.tready = 1'b0;
    vecs++;
    if (overflow !== 1'b0) begin
      errs++;
      $display("FAIL ovf_before: overflow=%b expected 0", overflow);
    end
    for (int i = 1; i <= 6; i++) send(8'(i), 3);
    repeat (6) send(8'hAC, 3);
    vecs++;
    if (overflow !== 1'b1 || axis.tvalid !== 1'b1 || axis.tdata !== 8'h01) begin
      errs++;
      $display("FAIL ovf_set: ovf=%b tvalid=%b tdata=%h expected 1/1/01", overflow, axis.tvalid, axis.tdata);
    end
    axis.tready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      vecs++;
      if (axis.tvalid !== 1'b1 || axis.tdata !== 8'(i)) begin
        errs++;
        $display("FAIL ovf_drain[%0d]: tvalid=%b tdata=%h expected 1/%h", i, axis.tvalid, axis.tdata, 8'(i));
      end
      send(8'hAC, 3);
    end
    vecs++;
    if (axis.tvalid !== 1'b0 || overflow !== 1'b1) begin
      errs++;
      $display("FAIL ovf_after: tvalid=%b ovf=%b expected 0/1", axis.tvalid, overflow);
    end
  endtask

  task automatic test_realign();
    axis.tready = 1'b1;
    repeat (5) send(8'hAC, 6);
    vecs++;
    if (locked !== 1'b1 || align_offset !== 3'd3) begin
      errs++;
      $display("FAIL unlock_early: locked=%b off=%0d expected 1/3", locked, align_offset);
    end
    send(8'hAC, 6);
    vecs++;
    if (locked !== 1'b0) begin
      errs++;
      $display("FAIL unlock: locked=%b expected 0", locked);
    end
    repeat (3) send(8'hAC, 6);
    vecs++;
    if (locked !== 1'b0) begin
      errs++;
      $display("FAIL relock_early: locked=%b expected 0", locked);
    end
    send(8'hAC, 6);
    vecs++;
    if (locked !== 1'b1 || align_offset !== 3'd6 || overflow !== 1'b1) begin
      errs++;
      $display("FAIL relock: locked=%b off=%0d ovf=%b expected 1/6/1", locked, align_offset, overflow);
    end
    repeat (3) send(8'hAC, 6);
  endtask

  task automatic test_reset_mid();
    axis.tready = 1'b0;
    send(8'h5A, 6);
    send(8'hA5, 6);
    repeat (4) send(8'hAC, 6);
    vecs++;
    if (axis.tvalid !== 1'b1 || axis.tdata !== 8'h5A) begin
      errs++;
      $display("FAIL pre_reset: tvalid=%b tdata=%h expected 1/5A", axis.tvalid, axis.tdata);
    end
    #2;
    RST = 1'b1;
    #1;
    vecs++;
    if (axis.tvalid !== 1'b0 || axis.tdata !== 8'h00 || locked !== 1'b0) begin
      errs++;
      $display("FAIL async_reset: tvalid=%b tdata=%h locked=%b expected 0/00/0", axis.tvalid, axis.tdata, locked);
    end
    vecs++;
    if (align_offset !== 3'd0 || overflow !== 1'b0) begin
      errs++;
      $display("FAIL async_reset_status: off=%0d ovf=%b expected 0/0", align_offset, overflow);
    end
    rx_data = 8'h00;
    last_b = 8'h00;
    @(posedge CLK);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    axis.tready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send(8'h00, 0);
      vecs++;
      if (axis.tvalid !== 1'b0) begin
        errs++;
        $display("FAIL stale_after_reset[%0d]: tvalid=%b tdata=%h expected 0", i, axis.tvalid, axis.tdata);
      end
    end
  endtask

  task automatic test_false_verify();
    send(8'hAC, 2);
    send(8'hAC, 2);
    send(8'h00, 2);
    vecs++;
    if (align_offset !== 3'd2 || locked !== 1'b0) begin
      errs++;
      $display("FAIL verify_enter: off=%0d locked=%b expected 2/0", align_offset, locked);
    end
    repeat (8) send(8'h00, 2);
    vecs++;
    if (locked !== 1'b0) begin
      errs++;
      $display("FAIL verify_noise: locked=%b expected 0", locked);
    end
    repeat (5) send(8'hAC, 2);
    vecs++;
    if (locked !== 1'b0) begin
      errs++;
      $display("FAIL verify_restart: locked=%b expected 0 (count must restart)", locked);
    end
    send(8'hAC, 2);
    vecs++;
    if (locked !== 1'b1 || align_offset !== 3'd2) begin
      errs++;
      $display("FAIL verify_lock: locked=%b off=%0d expected 1/2", locked, align_offset);
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_payload();
    test_overflow();
    test_realign();
    test_reset_mid();
    test_false_verify();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/iserdes_word_aligner.md
Name: iserdes_word_aligner

Overview:
- Fabric-side receiver for the serial link our OSERDES transmit path drives.
- Accepts raw 8-bit parallel words from an ISERDESE3 (DATA_WIDTH 8), one per CLK, with arbitrary bit rotation.
- Finds word alignment by hunting for a fixed idle/alignment byte across all 8 bit offsets, then locks.
- Emits aligned payload bytes on an AXI-Stream-style master interface through a small FIFO.

Parameters:
- ALIGN_WORD, 8'hAC, idle/training byte. Must not equal any nontrivial rotation of itself; 8'h00 and 8'hFF are illegal.
- LOCK_COUNT, 4, consecutive matches at the same offset needed to lock (1..15).
- UNLOCK_COUNT, 4, consecutive matches at one foreign offset, with no match at the locked offset, that drop lock (1..15).
- FIFO_DEPTH, 4, output FIFO entries (power of 2, 2..16).
- DROP_IDLE, 1, when 1 an aligned byte equal to ALIGN_WORD is not forwarded.

Ports:
- CLK, input, 1, single clock (ISERDES CLKDIV-rate domain); all logic is on its rising edge.
- RST, input, 1, asynchronous active-high reset.
- rx_data, input, 8, raw ISERDES word, sampled every cycle; bit 0 is the earliest-received bit.
- tdata, output, 8, aligned payload byte.
- tvalid, output, 1, tdata is valid.
- tready, input, 1, consumer accepts; a transfer occurs when tvalid && tready.
- locked, output, 1, aligner is in LOCKED.
- align_offset, output, 3, current/candidate bit offset.
- overflow, output, 1, sticky: a payload byte was dropped because the FIFO was full.

Behaviour:
- Reset (asynchronous, RST=1):
  - Outputs: tdata=0, tvalid=0, locked=0, align_offset=0, overflow=0.
  - State: state=SEARCH, FIFO empty, counters 0, history registers 0.
- Stage 1:
  - cur_q <= rx_data; prev_q <= cur_q.
  - window = {cur_q, prev_q} (16 bits). Candidate k (0..7) = window[k+7:k].
- match[k] = (candidate k == ALIGN_WORD). hit_off = lowest k with match[k]=1; any_hit = |match.
- States:
  - SEARCH:
    - If any_hit: align_offset<=hit_off, cnt<=1, go to VERIFY.
    - Otherwise stay.
  - VERIFY:
    - If match[align_offset]: cnt++.
      - When cnt reaches LOCK_COUNT, go to LOCKED and clear cnt.
      - With LOCK_COUNT=1, SEARCH goes directly to LOCKED.
    - Else if any_hit: restart VERIFY at hit_off with cnt=1.
    - Else: go to SEARCH with cnt=0.
    - Payload is never forwarded in VERIFY.
  - LOCKED:
    - locked=1.
    - Stage 2 registers candidate[align_offset] into word_q with a valid flag.
    - Unlock tracking:
      - If !match[align_offset] && any_hit: count consecutive cycles with the same hit_off. If hit_off changes, the count restarts at 1.
      - Any cycle with match[align_offset], or with no hit, clears the count.
    - When the count reaches UNLOCK_COUNT: go to SEARCH, locked<=0, FIFO contents retained.
- FIFO write:
  - Write word_q when its valid flag is set, unless DROP_IDLE=1 and word_q==ALIGN_WORD.
  - If the FIFO is full: word is discarded, overflow<=1. overflow clears only on RST.
- FIFO read:
  - First-word-fall-through; tdata/tvalid are registered from the FIFO head.
  - Simultaneous read and write while full is allowed: the read frees the slot, so no overflow.
  - tvalid held high and tdata held stable until accepted.
- Latency: rx_data sampled at edge n appears on tdata with tvalid=1 after edge n+3, given LOCKED, FIFO empty, and no intervening state change.
- The payload pipeline keeps draining after lock is lost. Words already in stage 2 are written.
- Reset mid-operation: immediate return to reset values; no partial word is emitted after RST deasserts.

Decomposition:
- Package iserdes_rx_pkg:
  - state enum {SEARCH, VERIFY, LOCKED}.
  - Default ALIGN_WORD constant.
  - Function extracting candidate k from a 16-bit window.
- Sub-module: sync_fwft_fifo (parameterised WIDTH/DEPTH, full/empty, same-cycle read+write while full).

Test Plan:
- Idle stream of 0xAC rotated to sit at offset 3 → locked=1 on the 4th consecutive match, align_offset=3, tvalid stays 0 (idles dropped).
- After lock, payload 0x11,0x22,0x33 embedded between idles, tready=1 → tdata 0x11,0x22,0x33 in order, each 3 cycles after its sample, and no idle on the output.
- tready=0, 6 payload bytes 0x01..0x06 → FIFO holds 0x01..0x04, overflow=1; raise tready → exactly 0x01..0x04 delivered, overflow remains 1.
- Locked at offset 3, then stream re-rotated to offset 6 → after 4 foreign matches locked=0. It relocks at offset 6 after 4 further matches; overflow unchanged.
- Pattern at offset 2 for two cycles, then random noise → returns SEARCH from VERIFY, locked never asserts.
- RST pulsed while LOCKED with 2 bytes queued → tvalid=0 and locked=0 immediately (asynchronous); no stale bytes appear after release.
